// File: rtl/reset_pkg.sv
// Shared types and default cycle counts for the PLL-domain reset sequencers.
package reset_pkg;

  typedef enum logic [2:0] {
    StWaitLock,
    StStable,
    StHold,
    StStagger,
    StRun
  } rstseq_state_t;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_STAGGER_CYCLES = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop bit synchronizer with synchronous active-low clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds peripheral and CPU resets until the PLL lock has been stable, then releases them
// in a fixed stagger; any lock loss re-asserts both and restarts qualification.
module pll_reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       periph_reset_n,
  output logic       cpu_reset_n,
  output logic       ready,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned CNT_W = $clog2(max3(STABLE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_TC = CNT_W'(STAGGER_CYCLES);

  rstseq_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       llc_q, llc_d;
  logic             periph_q, periph_d;
  logic             cpu_q, cpu_d;
  logic             lock_sync;
  logic             loss;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .clear_n (reset_n),
    .d       (pll_locked),
    .q       (lock_sync)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StWaitLock;
      cnt_q    <= '0;
      llc_q    <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      llc_q    <= llc_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        // The cycle that first sees lock counts towards the stable qualification.
        if (lock_sync) begin
          if (STABLE_CYCLES <= 1) begin
            state_d = StHold;
          end else begin
            state_d = StStable;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      StStable: begin
        if (!lock_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_inc == STABLE_TC) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold, StStagger: begin
        if (!lock_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          loss    = 1'b1;
        end else if (cnt_inc == ((state_q == StHold) ? HOLD_TC : STAGGER_TC)) begin
          state_d = (state_q == StHold) ? StStagger : StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_sync) begin
          state_d = StWaitLock;
          loss    = 1'b1;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the current state decode.
  always_comb begin
    periph_d = (state_q == StStagger) || (state_q == StRun);
    cpu_d    = (state_q == StRun);
    llc_d    = (loss && (llc_q != 8'hFF)) ? llc_q + 8'd1 : llc_q;
  end

  assign periph_reset_n  = periph_q;
  assign cpu_reset_n     = cpu_q;
  assign ready           = cpu_q;
  assign lock_loss_count = llc_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-on and lock-loss reset sequencer placed directly downstream of the system PLL. It synchronizes the PLL `locked` flag into one PLL output clock domain and waits for lock to be continuously stable. It then releases a peripheral reset followed, after a fixed stagger, by the CPU reset. Any loss of lock re-asserts both resets immediately and restarts the sequence.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before the hold phase.
- `HOLD_CYCLES`, 16: cycles resets stay asserted after lock is declared stable.
- `STAGGER_CYCLES`, 8: cycles between `periph_reset_n` and `cpu_reset_n` release (≥1).

Ports:
- `clk` in 1: a PLL output clock (system uses the 25 MHz output).
- `reset_n` in 1: board/button reset. One clock; reset is synchronous and active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `periph_reset_n` out 1: active-low reset for peripherals and the video/memory controllers.
- `cpu_reset_n` out 1: active-low reset for the CPU.
- `ready` out 1: high once the sequence has completed (equals `cpu_reset_n`).
- `lock_loss_count` out 8: number of lock losses seen after the stable point; saturates at 255.

## Operation
- States: WAIT_LOCK, STABLE, HOLD, STAGGER, RUN.
- WAIT_LOCK:
  - Both resets asserted; counter cleared.
  - Synchronized lock high → STABLE.
- STABLE:
  - Counter increments each cycle that synchronized lock is high.
  - Lock low → WAIT_LOCK, counter cleared, `lock_loss_count` unchanged.
  - Counter reaching `STABLE_CYCLES` → HOLD, counter cleared.
- HOLD:
  - Both resets asserted.
  - After `HOLD_CYCLES` cycles → STAGGER; `periph_reset_n` goes high.
- STAGGER:
  - `periph_reset_n` high, `cpu_reset_n` low.
  - After `STAGGER_CYCLES` cycles → RUN; `cpu_reset_n` and `ready` go high.
- RUN: holds until lock is lost.
- Lock loss in HOLD, STAGGER or RUN:
  - Next edge goes to WAIT_LOCK and drives both resets low.
  - `lock_loss_count` increments by 1, saturating at 255.
- `reset_n` low has priority over everything, in any state, including mid-count. On the next edge:
  - State → WAIT_LOCK.
  - Counter, synchronizer flops and `lock_loss_count` cleared.
  - Resets asserted.
- Counter width is `$clog2(max(STABLE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES)+1)`. The counter never wraps, because every terminal count changes state.

## Timing
- All outputs are registered; none is combinational from any input.
- Reset values: `periph_reset_n`=0, `cpu_reset_n`=0, `ready`=0, `lock_loss_count`=0, state WAIT_LOCK.
- Call N0 the first `clk` edge that samples `pll_locked`=1. With lock held high:
  - `periph_reset_n` rises at edge N0+`SYNC_STAGES`+`STABLE_CYCLES`+`HOLD_CYCLES`.
  - `cpu_reset_n` and `ready` rise exactly `STAGGER_CYCLES` edges later.
- Lock loss: resets fall at edge L+`SYNC_STAGES`+1, where L is the first edge sampling `pll_locked`=0.
- Lock re-rising in the same cycle that the loss is processed:
  - The loss wins.
  - The sequence restarts from WAIT_LOCK with full `STABLE_CYCLES` qualification.
- `pll_locked` pulses shorter than one `clk` period may be missed by the synchronizer; this is accepted behaviour.

## Structure
- Shared package `reset_pkg` holds:
  - the state enum `rstseq_state_t`;
  - the default cycle-count constants, reused by the top level for other clock domains.
- One sub-module, `sync_ff`: a generic `SYNC_STAGES`-deep bit synchronizer with synchronous active-low clear. It is reusable for other cross-domain flags.
- Top level instantiates one sequencer per PLL output domain that needs resets.

## Test plan
Benches use `SYNC_STAGES`=2, `STABLE_CYCLES`=8, `HOLD_CYCLES`=4, `STAGGER_CYCLES`=2.
- Clean lock: `pll_locked` 0→1 at N0 and held → `periph_reset_n` rises at N0+14, `cpu_reset_n`/`ready` at N0+16, `lock_loss_count`=0.
- Glitch during STABLE: lock low for 3 cycles at N0+6, then high → no reset release before the full 14-cycle qualification from the re-rise; `lock_loss_count` stays 0.
- Loss in RUN: drop lock at L → both resets low at L+3, `lock_loss_count`=1; lock re-rise gives full re-release timing.
- Saturation: 260 lock losses from RUN → `lock_loss_count`=255, no wrap.
- `reset_n` low for 1 cycle in STAGGER → next edge: both resets 0, `ready`=0, count 0; the sequence restarts and completes at the expected offsets.
- Lock never asserted for 10000 cycles → all outputs remain at reset values.
